// File: rtl/riscv_pkg.sv
// Shared pipeline types for the IF/ID boundary: the fetch packet, NOP encoding
// and the default depth of the IF->ID decoupling buffer.
package riscv_pkg;

    localparam int          IF_ID_BUF_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid_if_id;
    } if_id_reg_t;

    // What decode sees when nothing is buffered: a non-valid NOP bubble
    localparam if_id_reg_t IF_ID_EMPTY = '{
        pc:          32'h0,
        instruction: NOP_INSTR,
        pc_plus4:    32'h0,
        valid_if_id: 1'b0
    };

endpackage

// File: rtl/if_id_ptr_ctrl.sv
// Read/write pointers and entry count for the IF->ID circular buffer.
// Pointers wrap modulo DEPTH (power of two); count separates full from empty.
module if_id_ptr_ctrl #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic [AW-1:0] wp,
    output logic [AW-1:0] rp,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/if_id_buffer.sv
// IF->ID decoupling buffer: DEPTH-entry in-order queue between fetch and decode.
// Define IF_ID_BUF_BYPASS_EN to forward a packet straight to decode when empty.
module if_id_buffer
    import riscv_pkg::*;
#(
    parameter  int DEPTH = IF_ID_BUF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  if_id_reg_t  in_pkt,
    output logic        in_ready,
    input  logic        id_ready,
    output if_id_reg_t  out_pkt,
    output logic [AW:0] occupancy
);

    if_id_reg_t    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          full, empty;
    logic          push, pop, wr_en, byp;

`ifdef IF_ID_BUF_BYPASS_EN
    assign byp = empty & in_pkt.valid_if_id & ~flush;
`else
    assign byp = 1'b0;
`endif

    // in_ready depends only on registered count, never on id_ready
    assign in_ready = ~full;
    assign push     = in_pkt.valid_if_id & in_ready & ~flush;
    // A bypassed packet consumed by decode in the same cycle is never stored
    assign wr_en    = push & ~(byp & id_ready);
    assign pop      = ~empty & id_ready & ~flush;

    if_id_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .flush (flush),
        .wp    (wp),
        .rp    (rp),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= in_pkt;
    end

    always_comb begin
        out_pkt = IF_ID_EMPTY;
        if (!flush) begin
            if (!empty) begin
                out_pkt             = mem[rp];
                out_pkt.valid_if_id = 1'b1;
            end else if (byp) begin
                out_pkt = in_pkt;
            end
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed vector table, then queue-model random traffic.
module tb_if_id_buffer;
    import riscv_pkg::*;

    localparam int DEPTH = IF_ID_BUF_DEPTH;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          id_ready = 1'b0;
    if_id_reg_t    in_pkt;
    logic          in_ready;
    if_id_reg_t    out_pkt;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush),
        .in_pkt    (in_pkt),
        .in_ready  (in_ready),
        .id_ready  (id_ready),
        .out_pkt   (out_pkt),
        .occupancy (occupancy)
    );

    int checks = 0;
    int failures = 0;
    if_id_reg_t q[$];

    function automatic if_id_reg_t mk(input logic v, input logic [31:0] pc);
        if_id_reg_t p;
        p.pc          = pc;
        p.instruction = pc ^ 32'hA5A5_0033;
        p.pc_plus4    = pc + 32'd4;
        p.valid_if_id = v;
        return p;
    endfunction

    function automatic if_id_reg_t bubble();
        if_id_reg_t p;
        p.pc          = 32'h0;
        p.instruction = 32'h0000_0013;
        p.pc_plus4    = 32'h0;
        p.valid_if_id = 1'b0;
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ir, input logic fl);
        in_pkt   = mk(v, pc);
        id_ready = ir;
        flush    = fl;
    endtask

    // Reference: queue of held packets; decode sees the head, or the input
    // itself when bypass is built in and nothing is held.
    function automatic if_id_reg_t model_out();
        if_id_reg_t p;
        if (flush) return bubble();
        if (q.size() > 0) begin
            p = q[0];
            p.valid_if_id = 1'b1;
            return p;
        end
`ifdef IF_ID_BUF_BYPASS_EN
        if (in_pkt.valid_if_id) return in_pkt;
`endif
        return bubble();
    endfunction

    task automatic model_step();
        if_id_reg_t o;
        bit rdy, took_in;
        if (flush) begin
            q.delete();
            return;
        end
        rdy = (q.size() < DEPTH);
        o = model_out();
        took_in = 0;
        if (o.valid_if_id && id_ready) begin
            if (q.size() > 0) void'(q.pop_front());
            else took_in = 1;
        end
        if (in_pkt.valid_if_id && rdy && !took_in) q.push_back(in_pkt);
    endtask

    task automatic mcycle(input logic v, input logic [31:0] pc, input logic ir, input logic fl);
        @(negedge clk);
        drive(v, pc, ir, fl);
        #1;
        chk("in_ready", 128'(in_ready), 128'(q.size() < DEPTH));
        chk("occupancy", 128'(occupancy), 128'(q.size()));
        chk("out_pkt", 128'(out_pkt), 128'(model_out()));
        model_step();
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ir;
        logic        fl;
        int          occ;
        logic        rdy;
        logic        ov;
        logic [31:0] opc;
    } vec_t;

    vec_t tbl[21];

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        // idle, stream with id_ready, back-pressure, flush when full, flush with 1
        tbl[0]  = '{1'b0, 32'h000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        tbl[1]  = '{1'b1, 32'h000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        tbl[2]  = '{1'b1, 32'h004, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h000};
        tbl[3]  = '{1'b1, 32'h008, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h004};
        tbl[4]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h008};
        tbl[5]  = '{1'b0, 32'h000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        tbl[6]  = '{1'b1, 32'h010, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        tbl[7]  = '{1'b1, 32'h014, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h010};
        tbl[8]  = '{1'b1, 32'h018, 1'b0, 1'b0, 2, 1'b0, 1'b1, 32'h010};
        tbl[9]  = '{1'b1, 32'h018, 1'b1, 1'b0, 2, 1'b0, 1'b1, 32'h010};
        tbl[10] = '{1'b1, 32'h018, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h014};
        tbl[11] = '{1'b0, 32'h000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h018};
        tbl[12] = '{1'b0, 32'h000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        tbl[13] = '{1'b1, 32'h020, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        tbl[14] = '{1'b1, 32'h024, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h020};
        tbl[15] = '{1'b1, 32'h028, 1'b1, 1'b1, 2, 1'b0, 1'b0, 32'h000};
        tbl[16] = '{1'b1, 32'h100, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        tbl[17] = '{1'b0, 32'h000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h100};
        tbl[18] = '{1'b1, 32'h200, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h000};
        tbl[19] = '{1'b1, 32'h204, 1'b0, 1'b1, 1, 1'b1, 1'b0, 32'h000};
        tbl[20] = '{1'b0, 32'h000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h000};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
        chk("reset_occupancy", 128'(occupancy), 128'(0));
        chk("reset_out_pkt", 128'(out_pkt), 128'(bubble()));
        @(negedge clk);
        rst_n = 1'b1;

`ifndef IF_ID_BUF_BYPASS_EN
        if (DEPTH == 2) begin
            for (int i = 0; i < 21; i++) begin
                @(negedge clk);
                drive(tbl[i].v, tbl[i].pc, tbl[i].ir, tbl[i].fl);
                #1;
                chk($sformatf("vec%0d_occ", i), 128'(occupancy), 128'(tbl[i].occ));
                chk($sformatf("vec%0d_rdy", i), 128'(in_ready), 128'(tbl[i].rdy));
                chk($sformatf("vec%0d_ov", i), 128'(out_pkt.valid_if_id), 128'(tbl[i].ov));
                if (tbl[i].ov) begin
                    chk($sformatf("vec%0d_pc", i), 128'(out_pkt.pc), 128'(tbl[i].opc));
                    chk($sformatf("vec%0d_instr", i), 128'(out_pkt.instruction),
                        128'(tbl[i].opc ^ 32'hA5A5_0033));
                end else begin
                    chk($sformatf("vec%0d_nop", i), 128'(out_pkt.instruction), 128'(32'h13));
                end
            end
        end
`endif

        // sustained push+pop at occupancy 1 across several pointer wraps
        mcycle(1'b1, 32'h300, 1'b0, 1'b0);
        for (int i = 0; i < 4 * DEPTH; i++) mcycle(1'b1, 32'h304 + 32'(4 * i), 1'b1, 1'b0);
        mcycle(1'b0, 32'h0, 1'b1, 1'b0);
        mcycle(1'b0, 32'h0, 1'b0, 1'b0);

        // asynchronous reset while holding packets
        mcycle(1'b1, 32'h400, 1'b0, 1'b0);
        mcycle(1'b1, 32'h404, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pre_reset_occ", 128'(occupancy), 128'(q.size()));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_occ", 128'(occupancy), 128'(0));
        chk("async_rst_rdy", 128'(in_ready), 128'(1'b1));
        chk("async_rst_out", 128'(out_pkt), 128'(bubble()));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic against the queue model
        for (int i = 0; i < 500; i++) begin
            mcycle(1'($urandom_range(0, 9) < 7), 32'h1000 + 32'(4 * i),
                   1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) mcycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Decoupling buffer on the IF→ID boundary: the receiving end of the fetch stage's `if_id_reg_t` stream. It accepts fetched packets with a valid/ready handshake, holds up to DEPTH of them in order, and presents them to decode. It back-pressures fetch via `in_ready`, which the hazard unit inverts into `pc_stall`. A branch flush discards everything in flight.

## Interface
- `DEPTH`, default 2: entry count; power of two, ≥2.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `flush`  in  1: branch-taken flush from EX.
- `in_pkt`  in  `if_id_reg_t`: packet from IF. `in_pkt.valid_if_id` is the input valid.
- `in_ready`  out  1: buffer can accept a packet this cycle.
- `id_ready`  in  1: decode consumes the head packet this cycle.
- `out_pkt`  out  `if_id_reg_t`: head packet to ID. `out_pkt.valid_if_id` is the output valid.
- `occupancy`  out  `$clog2(DEPTH)+1`: entries held, 0..DEPTH.

## Operation
- Storage is a circular array of DEPTH `if_id_reg_t` entries with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits, plus a `count`.
- Pointers wrap modulo DEPTH naturally. `count` disambiguates full from empty.
- `in_ready` = (count != DEPTH). It is a function of registered state only; there is no combinational path from `id_ready` to `in_ready`.
- Push = `in_pkt.valid_if_id` & `in_ready` & !`flush`. On a push, write `in_pkt` at `wp` and advance `wp`.
- Pop = `out_pkt.valid_if_id` & `id_ready`. On a pop, advance `rp`.
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
- Non-empty output: `out_pkt` = entry[rp] with `valid_if_id`=1.
- Empty output: `out_pkt` = {pc=0, instruction=`NOP_INSTR` (32'h0000_0013), pc_plus4=0, valid_if_id=0}.
- Flush:
  - `out_pkt.valid_if_id` is forced to 0 in the flush cycle, so no pop occurs.
  - The input beat in that cycle is dropped.
  - At the edge, `wp`, `rp` and `count` go to 0.
- Full plus valid input: no push. IF must hold its packet, which happens because `pc_stall` = !`in_ready`.
- `id_ready` while empty: no effect.
- `occupancy` = `count`.

## Timing
- Reset values: `count`=0, `wp`=`rp`=0, `in_ready`=1, `occupancy`=0, `out_pkt` equals the empty-state value above.
- Storage contents are not reset.
- Reset is asynchronous and may assert mid-stream. All in-flight packets are lost, with the same outcome as a flush.
- Latency without bypass: a packet pushed at edge N is visible on `out_pkt` after edge N.
- Throughput is 1 packet/cycle sustained while `id_ready`=1, for DEPTH≥2.
- Full: `in_ready` falls in the cycle after the push that fills the buffer. It rises in the cycle after the first pop.
- Flush cycle: `in_ready` still reflects the pre-flush `count`, and the beat is dropped regardless. In the next cycle `in_ready`=1 and `occupancy`=0.

## Configuration
- Macro `IF_ID_BUF_BYPASS_EN`.
- When it is defined and `count`==0 and the input is valid and `flush`=0:
  - `out_pkt` = `in_pkt` combinationally, in the same cycle.
  - If `id_ready`=1, the packet is consumed directly and not written; `count` stays 0.
  - Otherwise the packet is written normally.
- When it is undefined: no combinational in→out path, and minimum latency is 1 cycle.
- `in_ready` behaviour is identical in both builds.

## Structure
- `riscv_pkg` holds `if_id_reg_t`, `NOP_INSTR`, and `IF_ID_BUF_DEPTH` (default 2).
- The pointer/count logic goes in one sub-module, `if_id_ptr_ctrl`. Inputs: push, pop, flush. Outputs: `wp`, `rp`, `count`, full, empty.
- The top level holds the storage array, the output mux and the bypass logic.

## Test plan
- Reset release, idle: `in_ready`=1, `occupancy`=0, `out_pkt.valid_if_id`=0, `out_pkt.instruction`=32'h0000_0013.
- Stream pc=0x0,0x4,0x8 with `id_ready`=1: outputs appear in order with 1-cycle latency (0 with `IF_ID_BUF_BYPASS_EN`), and `occupancy` never exceeds 1.
- `id_ready`=0 while pushing pc=0x10,0x14,0x18 at DEPTH=2:
  - `occupancy` reaches 2 and `in_ready` goes 0.
  - pc=0x18 is held, not lost.
  - After `id_ready`=1, outputs are 0x10,0x14,0x18.
- Flush with 2 entries plus a valid input in the same cycle: `out_pkt.valid_if_id`=0 that cycle, then `occupancy`=0 and `in_ready`=1, and the next packet (pc=0x100) is the next output.
- Simultaneous push and pop at `occupancy`=1: `occupancy` stays 1 and ordering is preserved across pointer wrap over ≥3 DEPTH cycles.
- Reset asserted with `occupancy`=2: outputs return to reset values immediately, asynchronously.
